// File: rtl/fir_mc_pkg.sv
// fir_mc_pkg: shared types and helpers for the multi-channel decimating FIR.
//   coef_t        signed coefficient type (8 bits)
//   COEF_DEFAULT  low-pass taps loaded at reset
//   state_t       control FSM states
//   coef_default  reset value lookup for tap index (zero beyond the table)
//   sat_round     round-half-up arithmetic shift followed by saturation
package fir_mc_pkg;

    localparam int COEF_W    = 8;
    localparam int COEF_NDEF = 8;

    typedef logic signed [COEF_W-1:0] coef_t;

    localparam coef_t COEF_DEFAULT [COEF_NDEF] = '{
        8'sd1, 8'sd3, 8'sd7, 8'sd11, 8'sd11, 8'sd7, 8'sd3, 8'sd1
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    function automatic coef_t coef_default(input int idx);
        if (idx >= 0 && idx < COEF_NDEF) begin
            return COEF_DEFAULT[idx];
        end
        return '0;
    endfunction

    // The accumulator is passed sign-extended to 64 bits so one helper serves
    // every lane width; the saturated result always fits in ow bits.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                     input int shift,
                                                     input int ow);
        logic signed [63:0] y;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        y  = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (y > hi) begin
            return hi;
        end
        if (y < lo) begin
            return lo;
        end
        return y;
    endfunction

endpackage

// File: rtl/fir_lane.sv
// fir_lane: one channel of the FIR - delay line, multiplier, accumulator and
// round/saturate output register. Sequencing comes from the parent.
//   clk, reset  clock and synchronous active-high reset
//   shift_en    push sample into x[0], shifting older samples up
//   sample      new signed input sample
//   mac_en      accumulate coef*x[tap] this cycle
//   mac_first   first tap: start accumulation from zero
//   mac_last    last tap: load the rounded, saturated result into y
//   tap         current tap index
//   coef        coefficient for the current tap
//   y           registered signed output, held between results
module fir_lane
    import fir_mc_pkg::*;
#(
    parameter int DW    = 5,
    parameter int OW    = 5,
    parameter int CW    = 8,
    parameter int NTAPS = 8,
    parameter int SHIFT = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         shift_en,
    input  logic signed [DW-1:0]         sample,
    input  logic                         mac_en,
    input  logic                         mac_first,
    input  logic                         mac_last,
    input  logic [$clog2(NTAPS)-1:0]     tap,
    input  logic signed [CW-1:0]         coef,
    output logic signed [OW-1:0]         y
);

    localparam int PW = DW + CW;
    localparam int AW = DW + CW + $clog2(NTAPS);

    logic signed [DW-1:0] x_reg [NTAPS];
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc_reg;
    logic signed [AW-1:0] acc_sum;
    logic signed [OW-1:0] y_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                x_reg[i] <= '0;
            end
        end else if (shift_en) begin
            x_reg[0] <= sample;
            for (int i = 1; i < NTAPS; i++) begin
                x_reg[i] <= x_reg[i-1];
            end
        end
    end

    assign prod = x_reg[tap] * coef;

    // Clearing on the first tap folds the "acc <= 0 on entry" into the first add.
    assign acc_sum = (mac_first ? '0 : acc_reg) + AW'(prod);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg <= '0;
            y_reg   <= '0;
        end else if (mac_en) begin
            acc_reg <= acc_sum;
            if (mac_last) begin
                y_reg <= OW'(sat_round(64'(acc_sum), SHIFT, OW));
            end
        end
    end

    assign y = y_reg;

endmodule

// File: rtl/fir_mc_decim.sv
// fir_mc_decim: NCH-lane FIR low-pass with shared control, run-time loadable
// shared coefficients and optional decimation.
//   clk, reset  clock and synchronous active-high reset
//   data_in     packed signed samples, lane k at [k*DW +: DW]
//   in_valid    data_in valid; in_ready high when a sample can be taken
//   coef_we     coefficient write strobe with coef_addr / coef_data
//   coef_err    same-cycle flag: write rejected (busy or address out of range)
//   data_out    packed signed results, lane k at [k*OW +: OW]
//   out_valid   one-cycle pulse marking a new data_out
module fir_mc_decim
    import fir_mc_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int DW    = 5,
    parameter int OW    = 5,
    parameter int CW    = 8,
    parameter int NTAPS = 8,
    parameter int SHIFT = 5,
    parameter int DECIM = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NCH*DW-1:0]           data_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        coef_we,
    input  logic [$clog2(NTAPS)-1:0]    coef_addr,
    input  logic signed [CW-1:0]        coef_data,
    output logic                        coef_err,
    output logic [NCH*OW-1:0]           data_out,
    output logic                        out_valid
);

    localparam int TW  = $clog2(NTAPS);
    localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;

    state_t             state_reg;
    state_t             state_next;
    logic [TW-1:0]      tap_reg;
    logic [TW-1:0]      tap_next;
    logic [DCW-1:0]     dcnt_reg;
    logic               out_valid_reg;

    logic               accept;
    logic               decim_hit;
    logic               tap_last;
    logic               mac_active;
    logic               mac_first;
    logic               addr_ok;
    logic               coef_wr;
    logic signed [CW-1:0] coef_arr [NTAPS];
    logic signed [CW-1:0] coef_sel;
    logic signed [OW-1:0] lane_y [NCH];

    assign in_ready   = (state_reg == IDLE);
    assign accept     = in_valid && in_ready;
    assign decim_hit  = (dcnt_reg == DCW'(DECIM - 1));
    assign tap_last   = (tap_reg == TW'(NTAPS - 1));
    assign mac_active = (state_reg == MAC);
    assign mac_first  = mac_active && (tap_reg == '0);

    // Writes land only while idle so a running computation never sees a
    // coefficient change mid-sum; a sample taken in the same cycle still
    // starts its MAC afterwards and therefore uses the new value.
    assign addr_ok  = ({1'b0, coef_addr} < (TW+1)'(NTAPS));
    assign coef_wr  = coef_we && in_ready && addr_ok;
    assign coef_err = coef_we && !reset && !(in_ready && addr_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tap_next   = '0;
        case (state_reg)
            IDLE: begin
                if (accept && decim_hit) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                tap_next = tap_reg + TW'(1);
                if (tap_last) begin
                    state_next = OUT;
                    tap_next   = '0;
                end
            end
            OUT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // out_valid is registered off the last tap so it is high during OUT,
    // NTAPS+1 cycles after the accepting cycle, alongside the fresh result.
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_reg       <= '0;
            dcnt_reg      <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            tap_reg       <= tap_next;
            out_valid_reg <= mac_active && tap_last;
            if (accept) begin
                dcnt_reg <= decim_hit ? '0 : dcnt_reg + DCW'(1);
            end
        end
    end

    assign out_valid = out_valid_reg;

    genvar gi;

    for (gi = 0; gi < NTAPS; gi++) begin : g_coef
        localparam logic signed [CW-1:0] C_RST = CW'(coef_default(gi));
        logic signed [CW-1:0] c_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                c_reg <= C_RST;
            end else if (coef_wr && (coef_addr == TW'(gi))) begin
                c_reg <= coef_data;
            end
        end

        assign coef_arr[gi] = c_reg;
    end

    assign coef_sel = coef_arr[tap_reg];

    for (gi = 0; gi < NCH; gi++) begin : g_lane
        fir_lane #(
            .DW    (DW),
            .OW    (OW),
            .CW    (CW),
            .NTAPS (NTAPS),
            .SHIFT (SHIFT)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .shift_en  (accept),
            .sample    ($signed(data_in[gi*DW +: DW])),
            .mac_en    (mac_active),
            .mac_first (mac_first),
            .mac_last  (tap_last),
            .tap       (tap_reg),
            .coef      (coef_sel),
            .y         (lane_y[gi])
        );

        assign data_out[gi*OW +: OW] = lane_y[gi];
    end

endmodule

// File: tb/tb_fir_mc_decim.sv
// tb_fir_mc_decim: drives three fir_mc_decim instances from one shared input
// bus (defaults; DECIM=2; NTAPS=6) and checks each against a sample-history
// reference model through an expected-result queue and a separate monitor.
module tb_fir_mc_decim;

    localparam int NI = 3;
    localparam int NT [NI] = '{8, 8, 6};
    localparam int DC [NI] = '{1, 2, 1};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] data_in = '0;
    logic       in_valid = 1'b0;
    logic       coef_we = 1'b0;
    logic [2:0] coef_addr = '0;
    logic [7:0] coef_data = '0;
    logic [9:0] dout [NI];
    logic [NI-1:0] rdy;
    logic [NI-1:0] cerr;
    logic [NI-1:0] ov;

    always #5 clk = ~clk;

    fir_mc_decim #(.DECIM(1)) dut_a (
        .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
        .in_ready(rdy[0]), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_err(cerr[0]), .data_out(dout[0]),
        .out_valid(ov[0])
    );

    fir_mc_decim #(.DECIM(2)) dut_b (
        .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
        .in_ready(rdy[1]), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_err(cerr[1]), .data_out(dout[1]),
        .out_valid(ov[1])
    );

    fir_mc_decim #(.NTAPS(6)) dut_c (
        .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
        .in_ready(rdy[2]), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_err(cerr[2]), .data_out(dout[2]),
        .out_valid(ov[2])
    );

    typedef struct {
        int inst;
        int y0;
        int y1;
        int cyc;
    } exp_t;

    exp_t expq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   hist [NI][2][8];
    int   mc [NI][8];
    int   busy [NI];
    int   dcnt [NI];
    int   last_y [NI][2];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic int ref_y(int i, int l);
        int acc;
        int y;
        acc = 0;
        for (int k = 0; k < NT[i]; k++) acc += mc[i][k] * hist[i][l][k];
        y = (acc + 16) >>> 5;
        if (y > 15) y = 15;
        if (y < -16) y = -16;
        return y;
    endfunction

    task automatic model_reset();
        int def [8] = '{1, 3, 7, 11, 11, 7, 3, 1};
        expq.delete();
        for (int i = 0; i < NI; i++) begin
            busy[i] = 0;
            dcnt[i] = 0;
            last_y[i][0] = 0;
            last_y[i][1] = 0;
            for (int k = 0; k < 8; k++) begin
                mc[i][k] = def[k];
                hist[i][0][k] = 0;
                hist[i][1][k] = 0;
            end
        end
    endtask

    function automatic int lane_val(logic [9:0] d, int l);
        logic signed [4:0] v;
        v = d[l*5 +: 5];
        return int'(v);
    endfunction

    // One clock cycle of stimulus, entered and left 1 time unit after posedge.
    task automatic step(bit v, int s0, int s1, bit we = 0, int addr = 0, int cd = 0);
        bit exp_rdy;
        bit exp_err;
        exp_t e;
        in_valid  = v;
        data_in   = {s1[4:0], s0[4:0]};
        coef_we   = we;
        coef_addr = addr[2:0];
        coef_data = cd[7:0];
        #1;
        for (int i = 0; i < NI; i++) begin
            exp_rdy = (busy[i] == 0);
            exp_err = we && (busy[i] != 0 || addr >= NT[i]);
            checks++;
            if (rdy[i] !== exp_rdy) begin
                failures++;
                $display("FAIL in_ready inst%0d cyc=%0d got=%b want=%b", i, cyc, rdy[i], exp_rdy);
            end
            checks++;
            if (cerr[i] !== exp_err) begin
                failures++;
                $display("FAIL coef_err inst%0d cyc=%0d got=%b want=%b", i, cyc, cerr[i], exp_err);
            end
            if (we && !exp_err) mc[i][addr] = cd;
            if (v && busy[i] == 0) begin
                for (int k = 7; k > 0; k--) begin
                    hist[i][0][k] = hist[i][0][k-1];
                    hist[i][1][k] = hist[i][1][k-1];
                end
                hist[i][0][0] = s0;
                hist[i][1][0] = s1;
                if (dcnt[i] == DC[i] - 1) begin
                    dcnt[i] = 0;
                    busy[i] = NT[i] + 2;
                    e.inst = i;
                    e.y0   = ref_y(i, 0);
                    e.y1   = ref_y(i, 1);
                    e.cyc  = cyc + NT[i] + 1;
                    expq.push_back(e);
                end else begin
                    dcnt[i]++;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) if (busy[i] > 0) busy[i]--;
    endtask

    task automatic do_reset(int n);
        reset    = 1'b1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- monitor ----------------
    task automatic check_inst(int i);
        int idx;
        int g0;
        int g1;
        exp_t e;
        g0 = lane_val(dout[i], 0);
        g1 = lane_val(dout[i], 1);
        if (ov[i] === 1'b1) begin
            idx = -1;
            for (int k = 0; k < expq.size(); k++) begin
                if (expq[k].inst == i) begin
                    idx = k;
                    break;
                end
            end
            checks++;
            if (idx < 0) begin
                failures++;
                $display("FAIL unexpected_out inst%0d cyc=%0d got=%0d,%0d want=no output", i, cyc, g0, g1);
            end else begin
                e = expq[idx];
                expq.delete(idx);
                if (g0 != e.y0 || g1 != e.y1 || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL output inst%0d got=%0d,%0d@cyc%0d want=%0d,%0d@cyc%0d",
                             i, g0, g1, cyc, e.y0, e.y1, e.cyc);
                end else begin
                    $display("out inst%0d cyc=%0d y=%0d,%0d ok", i, cyc, g0, g1);
                end
                last_y[i][0] = e.y0;
                last_y[i][1] = e.y1;
            end
        end else begin
            checks++;
            if (g0 != last_y[i][0] || g1 != last_y[i][1]) begin
                failures++;
                $display("FAIL hold inst%0d cyc=%0d got=%0d,%0d want=%0d,%0d",
                         i, cyc, g0, g1, last_y[i][0], last_y[i][1]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NI; i++) check_inst(i);
        end
    end

    // ---------------- stimulus ----------------
    task automatic impulse_run();
        for (int n = 0; n < 11; n++) begin
            step(1, (n == 1) ? 8 : 0, 0);
            repeat (9) step(0, 0, 0);
        end
    endtask

    initial begin
        int left;
        model_reset();
        do_reset(3);

        // Impulse on lane 0, zeros on lane 1, one sample per 10 cycles.
        impulse_run();

        // in_valid held high with random data: drops while busy, latency checks.
        for (int n = 0; n < 60; n++)
            step(1, $urandom_range(0, 31) - 16, $urandom_range(0, 31) - 16);

        // DC levels including both saturation limits.
        for (int n = 0; n < 100; n++) step(1, 10, -16);
        for (int n = 0; n < 100; n++) step(1, 15, -16);

        // Random valid, data and coefficient writes.
        for (int n = 0; n < 300; n++)
            step($urandom_range(0, 1), $urandom_range(0, 31) - 16, $urandom_range(0, 31) - 16,
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 7), $urandom_range(0, 255) - 128);
        repeat (12) step(0, 0, 0);

        // Coefficient write together with the impulse, then writes while busy
        // and beyond the 6-tap instance's range.
        do_reset(2);
        step(1, 8, 0, 1, 0, 32);
        step(0, 0, 0, 1, 3, 99);
        step(0, 0, 0, 1, 7, 5);
        repeat (12) step(0, 0, 0);
        step(0, 0, 0, 1, 6, 9);
        step(0, 0, 0, 1, 7, -4);
        step(1, -8, 7);
        repeat (12) step(0, 0, 0);

        // Reset in the middle of MAC, then the impulse run again.
        step(1, 5, -3);
        repeat (4) step(0, 0, 0);
        do_reset(2);
        impulse_run();
        repeat (20) step(0, 0, 0);

        for (int i = 0; i < NI; i++) begin
            left = 0;
            foreach (expq[k]) if (expq[k].inst == i) left++;
            checks++;
            if (left != 0) begin
                failures++;
                $display("FAIL drain inst%0d got=%0d pending want=0", i, left);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
